// File: rtl/apple_placer_pkg.sv
// apple_placer_pkg
// Shared definitions for the snake game blocks: default grid geometry, the cell
// count, the apple placer FSM state encoding and the LFSR step function.
// No ports; imported with "import apple_placer_pkg::*;".
package apple_placer_pkg;

   localparam int GRID_W_DEF = 7;
   localparam int GRID_H_DEF = 6;
   localparam int CELLS_DEF  = GRID_W_DEF * GRID_H_DEF;

   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_MASK = 8'hB8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
   endfunction

endpackage

// File: rtl/apple_placer_lfsr.sv
// apple_lfsr
// Free-running 8-bit Galois LFSR used as the random source for apple placement.
// Ports:
//   i_Clk    game clock
//   i_Reset  synchronous active-high reset, loads LFSR_SEED
//   o_Value  current LFSR state (never zero for a nonzero seed)
module apple_lfsr
   import apple_placer_pkg::*;
#(
   parameter logic [7:0] LFSR_SEED = 8'hA5
)(
   input  logic       i_Clk,
   input  logic       i_Reset,
   output logic [7:0] o_Value
);

   logic [7:0] r_Lfsr;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Lfsr <= LFSR_SEED;
      end else begin
         r_Lfsr <= lfsr_step(r_Lfsr);
      end
   end

   assign o_Value = r_Lfsr;

endmodule

// File: rtl/apple_placer.sv
// apple_placer
// Picks a pseudo-random free grid cell for the next apple. Starting from a cell
// derived from the LFSR, it probes one cell per clock in raster order (wrapping
// at the last cell) until it finds one not covered by the snake, or reports that
// the grid is full after probing every cell once.
// Ports:
//   i_Clk        game clock
//   i_Reset      synchronous active-high reset
//   i_Req        placement request, accepted only when idle
//   i_Occupied   occupancy bitmap, bit n = cell Y*GRID_W+X; hold stable while busy
//   o_Busy       placement in progress
//   o_Valid      one-cycle pulse when a placement finishes
//   o_Full       no free cell found; stays set until the next accepted request
//   o_Apple_X/Y  apple coordinates, updated only when a free cell is found
//   o_Probe_Cnt  (only with APPLE_PLACER_PROBE_CNT_EN) probes used by the last
//                placement, 0 when the first probe was free
// Build option: APPLE_PLACER_PROBE_CNT_EN adds o_Probe_Cnt; placement is identical.
module apple_placer
   import apple_placer_pkg::*;
#(
   parameter int         GRID_W    = GRID_W_DEF,
   parameter int         GRID_H    = GRID_H_DEF,
   parameter logic [7:0] LFSR_SEED = 8'hA5
)(
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic                     i_Req,
   input  logic [GRID_W*GRID_H-1:0] i_Occupied,
   output logic                     o_Busy,
   output logic                     o_Valid,
   output logic                     o_Full,
   output logic [2:0]               o_Apple_X,
   output logic [2:0]               o_Apple_Y
`ifdef APPLE_PLACER_PROBE_CNT_EN
   ,
   output logic [5:0]               o_Probe_Cnt
`endif
);

   localparam int         CELLS     = GRID_W * GRID_H;
   localparam logic [5:0] LAST_CELL = 6'(CELLS - 1);

   // Fold the raw 3-bit LFSR fields back into the grid by subtracting the
   // dimension once (7 -> 0 for columns; 6 -> 0, 7 -> 1 for rows).
   function automatic logic [5:0] start_cell(input logic [7:0] l);
      logic [2:0] x;
      logic [2:0] y;
      x = l[2:0];
      y = l[5:3];
      if (x >= 3'(GRID_W)) x = x - 3'(GRID_W);
      if (y >= 3'(GRID_H)) y = y - 3'(GRID_H);
      return {y, x};
   endfunction

   logic [7:0] w_Lfsr;

   apple_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .o_Value (w_Lfsr)
   );

   state_t     r_State, w_NextState;
   logic [2:0] r_Cx, r_Cy, w_NextCx, w_NextCy;
   logic [5:0] r_Cnt, w_NextCnt;
   logic [2:0] r_AppleX, r_AppleY, w_NextAppleX, w_NextAppleY;
   logic       r_Full, w_NextFull;
   logic [5:0] w_Idx;
   logic       w_Free;
   logic [5:0] w_Start;

   // Constant multiply by the grid width keeps the index a shift/add tree
   assign w_Idx   = 6'(r_Cy) * 6'(GRID_W) + 6'(r_Cx);
   assign w_Free  = ~i_Occupied[w_Idx];
   assign w_Start = start_cell(w_Lfsr);

   always_comb begin
      w_NextState  = r_State;
      w_NextCx     = r_Cx;
      w_NextCy     = r_Cy;
      w_NextCnt    = r_Cnt;
      w_NextAppleX = r_AppleX;
      w_NextAppleY = r_AppleY;
      w_NextFull   = r_Full;
      case (r_State)
         ST_IDLE: begin
            if (i_Req) begin
               w_NextCx    = w_Start[2:0];
               w_NextCy    = w_Start[5:3];
               w_NextCnt   = 6'd0;
               w_NextFull  = 1'b0;
               w_NextState = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (w_Free) begin
               w_NextAppleX = r_Cx;
               w_NextAppleY = r_Cy;
               w_NextState  = ST_DONE;
            end else if (r_Cnt == LAST_CELL) begin
               // Every cell probed once and all were occupied
               w_NextCnt   = r_Cnt + 6'd1;
               w_NextFull  = 1'b1;
               w_NextState = ST_DONE;
            end else begin
               w_NextCnt = r_Cnt + 6'd1;
               if (r_Cx == 3'(GRID_W - 1)) begin
                  w_NextCx = 3'd0;
                  w_NextCy = (r_Cy == 3'(GRID_H - 1)) ? 3'd0 : r_Cy + 3'd1;
               end else begin
                  w_NextCx = r_Cx + 3'd1;
               end
            end
         end
         ST_DONE: begin
            w_NextState = ST_IDLE;
         end
         default: begin
            w_NextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State  <= ST_IDLE;
         r_AppleX <= 3'd0;
         r_AppleY <= 3'd0;
         r_Full   <= 1'b0;
      end else begin
         r_State  <= w_NextState;
         r_AppleX <= w_NextAppleX;
         r_AppleY <= w_NextAppleY;
         r_Full   <= w_NextFull;
      end
   end

   // Scan pointer and probe counter are always loaded before use
   always_ff @(posedge i_Clk) begin
      r_Cx  <= w_NextCx;
      r_Cy  <= w_NextCy;
      r_Cnt <= w_NextCnt;
   end

`ifdef APPLE_PLACER_PROBE_CNT_EN
   logic [5:0] r_ProbeCnt;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_ProbeCnt <= 6'd0;
      end else if (r_State == ST_SCAN && w_NextState == ST_DONE) begin
         r_ProbeCnt <= w_NextCnt;
      end
   end

   assign o_Probe_Cnt = r_ProbeCnt;
`endif

   assign o_Busy    = (r_State == ST_SCAN);
   assign o_Valid   = (r_State == ST_DONE);
   assign o_Full    = r_Full;
   assign o_Apple_X = r_AppleX;
   assign o_Apple_Y = r_AppleY;

endmodule

// File: tb/tb_apple_placer.sv
// tb_apple_placer
// Directed bench for apple_placer (default build, 7x6 grid, seed 8'hA5).
module tb_apple_placer;

   localparam logic [41:0] ALL_OCC  = {42{1'b1}};
   localparam logic [41:0] ALL_FREE = 42'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [41:0] occ;
   logic        busy, valid, full;
   logic [2:0]  ax, ay;

   always #5 clk = ~clk;

   apple_placer #(.GRID_W(7), .GRID_H(6), .LFSR_SEED(8'hA5)) dut (
      .i_Clk      (clk),
      .i_Reset    (rst),
      .i_Req      (req),
      .i_Occupied (occ),
      .o_Busy     (busy),
      .o_Valid    (valid),
      .o_Full     (full),
      .o_Apple_X  (ax),
      .o_Apple_Y  (ay)
   );

   // Reference LFSR: right-shift Galois, taps x^8+x^6+x^5+x^4+1
   logic [7:0] m_lfsr;
   always @(posedge clk) begin
      if (rst) m_lfsr <= 8'hA5;
      else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int start_x(input logic [7:0] l);
      int x;
      x = int'(l[2:0]);
      if (x == 7) x = 0;
      return x;
   endfunction

   function automatic int start_y(input logic [7:0] l);
      int y;
      y = int'(l[5:3]);
      if (y == 6) y = 0;
      else if (y == 7) y = 1;
      return y;
   endfunction

   function automatic int start_idx(input logic [7:0] l);
      return start_y(l) * 7 + start_x(l);
   endfunction

   // Called at a negedge while idle. Returns at the negedge where o_Valid is
   // seen; d is the spec-style latency (2 = first probe free), 0 on timeout.
   task automatic place(input logic [41:0] o, output int sx, output int sy, output int d);
      occ = o;
      sx  = start_x(m_lfsr);
      sy  = start_y(m_lfsr);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      d   = 0;
      for (int e = 0; e < 60; e++) begin
         if (valid) begin
            d = e + 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int sx, sy, d, s, nv, distinct;
      logic [255:0] seen;
      logic [7:0]   v;
      logic         found;

      rst = 1'b1; req = 1'b0; occ = ALL_FREE;
      idle(3);
      rst = 1'b0;

      // Reset state
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_x",     32'(ax),    32'd0);
      chk("rst_y",     32'(ay),    32'd0);
      chk("rst_lfsr",  32'(dut.u_lfsr.o_Value), 32'hA5);

      // 1: all free, two different phases
      for (int r = 0; r < 2; r++) begin
         idle(r * 3 + 1);
         place(ALL_FREE, sx, sy, d);
         chk("t1_lat",  32'(d),    32'd2);
         chk("t1_full", 32'(full), 32'd0);
         chk("t1_x",    32'(ax),   32'(sx));
         chk("t1_y",    32'(ay),   32'(sy));
         @(negedge clk);
         chk("t1_pulse", 32'(valid), 32'd0);
      end

      // 2: only cell 41 free, random phases
      for (int r = 0; r < 20; r++) begin
         idle(1 + int'($urandom_range(0, 9)));
         s = start_idx(m_lfsr);
         place(~(42'd1 << 41), sx, sy, d);
         chk("t2_x",   32'(ax), 32'd6);
         chk("t2_y",   32'(ay), 32'd5);
         chk("t2_lat", 32'(d),  32'(43 - s));
         @(negedge clk);
      end

      // 3: only cell 0 free, late start forces a wrap
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (start_idx(m_lfsr) >= 21) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("t3_phase", 32'(found), 32'd1);
      s = start_idx(m_lfsr);
      place(42'd1 ^ ALL_OCC, sx, sy, d);
      chk("t3_x",   32'(ax), 32'd0);
      chk("t3_y",   32'(ay), 32'd0);
      chk("t3_lat", 32'(d),  32'(2 + 42 - s));
      @(negedge clk);

      // 4: park apple at (4,2), then a full grid leaves it unchanged
      place(~(42'd1 << 18), sx, sy, d);
      chk("t4_pre_x", 32'(ax), 32'd4);
      chk("t4_pre_y", 32'(ay), 32'd2);
      @(negedge clk);
      place(ALL_OCC, sx, sy, d);
      chk("t4_lat",  32'(d),    32'd43);
      chk("t4_full", 32'(full), 32'd1);
      chk("t4_x",    32'(ax),   32'd4);
      chk("t4_y",    32'(ay),   32'd2);
      idle(2);
      chk("t4_sticky", 32'(full), 32'd1);
      place(ALL_FREE, sx, sy, d);
      chk("t4_clr", 32'(full), 32'd0);
      @(negedge clk);

      // 5a: extra request during the scan is ignored
      occ = ALL_OCC;
      req = 1'b1;
      @(negedge clk);
      nv = 0;
      for (int e = 0; e < 60; e++) begin
         req = (e == 5 || e == 42) ? 1'b1 : 1'b0;
         if (valid) nv++;
         @(negedge clk);
      end
      req = 1'b0;
      chk("t5_one_valid", 32'(nv), 32'd1);
      chk("t5_idle", 32'(busy), 32'd0);

      // 5b: reset in the middle of a scan
      place(~(42'd1 << 18), sx, sy, d);
      chk("t5_pre_x", 32'(ax), 32'd4);
      @(negedge clk);
      occ = ALL_OCC;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      idle(10);
      chk("t5_busy_mid", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_busy",  32'(busy),  32'd0);
      chk("t5_rst_valid", 32'(valid), 32'd0);
      chk("t5_rst_x",     32'(ax),    32'd0);
      chk("t5_rst_y",     32'(ay),    32'd0);
      rst = 1'b0;
      nv = 0;
      for (int e = 0; e < 50; e++) begin
         if (valid) nv++;
         @(negedge clk);
      end
      chk("t5_no_valid", 32'(nv), 32'd0);

      // 6: LFSR period after reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = '0;
      distinct = 0;
      for (int i = 0; i < 255; i++) begin
         v = dut.u_lfsr.o_Value;
         if (v != 8'd0 && !seen[v]) distinct++;
         seen[v] = 1'b1;
         @(negedge clk);
      end
      chk("t6_distinct", 32'(distinct), 32'd255);
      chk("t6_return",   32'(dut.u_lfsr.o_Value), 32'hA5);
      chk("t6_model",    32'(dut.u_lfsr.o_Value), 32'(m_lfsr));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
